// File: rtl/addr_arb_mux.sv
// addr_arb_mux: registered N:1 address multiplexer with round-robin arbitration.
// Requesting channels raise a level req. One owner is granted at a time and
// keeps the port until it drops req; there is no preemption. After each release
// the arbiter spends exactly one idle cycle, and the search for the next owner
// starts just above the channel that last released.
// Ports:
//   clk        rising-edge clock
//   nrst       synchronous reset, active-low (overrides en)
//   en         global enable; 0 freezes every register
//   req        per-channel level request
//   addr_in    packed channel addresses, channel k at [k*WORD_WIDTH +: WORD_WIDTH]
//   grant      registered one-hot owner, all-zero when idle
//   grant_id   registered binary owner index, 0 when idle
//   addr_out   registered owner address, 0 when idle
//   addr_valid high while addr_out carries an owner's address
module addr_arb_mux #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned ID_W       = 3
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         en,
  input  logic [NUM_CH-1:0]            req,
  input  logic [NUM_CH*WORD_WIDTH-1:0] addr_in,
  output logic [NUM_CH-1:0]            grant,
  output logic [ID_W-1:0]              grant_id,
  output logic [WORD_WIDTH-1:0]        addr_out,
  output logic                         addr_valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state_q, state_d;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0]       grant_d;
  logic [ID_W-1:0]         grant_id_d;
  logic [WORD_WIDTH-1:0]   addr_out_d;
  logic                    addr_valid_d;

  logic [WORD_WIDTH-1:0]   addr_arr [NUM_CH];
  logic                    found;
  logic [ID_W-1:0]         win;
  logic [NUM_CH-1:0]       win_onehot;
  logic [ID_W-1:0]         owner_next;

  // Unpack the flat address bus into one word per channel.
  for (genvar k = 0; k < int'(NUM_CH); k++) begin : g_unpack
    assign addr_arr[k] = addr_in[k*WORD_WIDTH +: WORD_WIDTH];
  end

  // Round-robin search: first set req at or above rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    int unsigned     idx;
    logic [ID_W-1:0] idx_w;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    idx_w = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      idx_w = ID_W'(idx);
      if (!found && req[idx_w]) begin
        found = 1'b1;
        win   = idx_w;
      end
    end
  end

  always_comb begin
    win_onehot      = '0;
    win_onehot[win] = 1'b1;
  end

  // Pointer value after the current owner releases, wrapping NUM_CH-1 -> 0.
  assign owner_next = (grant_id == ID_W'(NUM_CH - 1)) ? '0 : grant_id + ID_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant;
    grant_id_d   = grant_id;
    addr_out_d   = addr_out;
    addr_valid_d = addr_valid;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = BUSY;
          grant_d      = win_onehot;
          grant_id_d   = win;
          addr_out_d   = addr_arr[win];
          addr_valid_d = 1'b1;
        end else begin
          grant_d      = '0;
          grant_id_d   = '0;
          addr_out_d   = '0;
          addr_valid_d = 1'b0;
        end
      end
      BUSY: begin
        if (req[grant_id]) begin
          addr_out_d = addr_arr[grant_id];
        end else begin
          state_d      = IDLE;
          rr_ptr_d     = owner_next;
          grant_d      = '0;
          grant_id_d   = '0;
          addr_out_d   = '0;
          addr_valid_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        grant_d      = '0;
        grant_id_d   = '0;
        addr_out_d   = '0;
        addr_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; en=0 holds everything.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant      <= '0;
      grant_id   <= '0;
      addr_out   <= '0;
      addr_valid <= 1'b0;
    end else if (en) begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant      <= grant_d;
      grant_id   <= grant_id_d;
      addr_out   <= addr_out_d;
      addr_valid <= addr_valid_d;
    end
  end

endmodule
